dcache_meta_write_port: RTL

// - Consumer end of the 8-way priority meta-write arbiter: accepts one arbitrated tag write per cycle (idx/way_en/tag).
// - Buffers writes in a small FIFO and drains them into the single-ported dcache tag array when no tag read owns the port.
// - Guarantees forward progress under read pressure with a starvation counter.
// - Exposes a pending-index probe so readers can detect stale tags.

---
 rtl/dcache_meta_pkg.sv | 18 +
 rtl/meta_write_fifo.sv | 81 ++++++++
 rtl/dcache_meta_write_port.sv | 96 +++++++++
 3 files changed

// File: rtl/dcache_meta_pkg.sv
// Shared types and sizing for the dcache tag-array write port.
// The FIFO and the issue logic both depend on these.
package dcache_meta_pkg;

    localparam int IDX_W        = 6;
    localparam int WAYS         = 8;
    localparam int TAG_W        = 20;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WAYS-1:0]  way_en;
        logic [TAG_W-1:0] tag;
    } meta_write_t;

endpackage

// File: rtl/meta_write_fifo.sv
// Circular buffer of pending tag writes.
// Supports push, pop, tail overwrite and exposes per-entry valid bits.
module meta_write_fifo
    import dcache_meta_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 ovr_i,
    input  meta_write_t          wdata_i,
    output meta_write_t          head_o,
    output logic [IDX_W-1:0]     tail_idx_o,
    output logic [WAYS-1:0]      tail_way_o,
    output meta_write_t          ent_o [N],
    output logic [N-1:0]         valid_o,
    output logic                 one_o,
    output logic                 empty_o,
    output logic                 full_o
);

    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    meta_write_t        mem_q [N];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W-1:0]   last;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign last = tail_q - PTR_W'(1);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (pop_i)  head_d = head_q + PTR_W'(1);
        if (push_i) tail_d = tail_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[tail_q] <= wdata_i;
        else if (ovr_i)
            mem_q[last].tag <= wdata_i.tag;
    end

    always_comb begin
        logic [PTR_W-1:0] off;
        valid_o = '0;
        for (int i = 0; i < N; i++) begin
            off        = PTR_W'(i) - head_q;
            valid_o[i] = CNT_W'(off) < cnt_q;
            ent_o[i]   = mem_q[i];
        end
    end

    assign head_o     = mem_q[head_q];
    assign tail_idx_o = mem_q[last].idx;
    assign tail_way_o = mem_q[last].way_en;
    assign one_o      = cnt_q == CNT_W'(1);
    assign empty_o    = cnt_q == '0;
    assign full_o     = cnt_q == CNT_W'(N);

endmodule

// File: rtl/dcache_meta_write_port.sv
// Buffers arbitrated tag writes and drains them into the single-ported
// tag array, forcing a write after a bounded run of blocking reads.
module dcache_meta_write_port
    import dcache_meta_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic [IDX_W-1:0] io_req_bits_idx,
    input  logic [WAYS-1:0]  io_req_bits_way_en,
    input  logic [TAG_W-1:0] io_req_bits_tag,
    input  logic             io_read_active,
    output logic             io_read_block,
    output logic             io_array_wen,
    output logic [IDX_W-1:0] io_array_idx,
    output logic [WAYS-1:0]  io_array_way_en,
    output logic [TAG_W-1:0] io_array_tag,
    input  logic [IDX_W-1:0] io_probe_idx,
    output logic             io_probe_pending,
    output logic             io_busy
);

    meta_write_t             head, wdata;
    meta_write_t             ent [DEPTH];
    logic [IDX_W-1:0]        tail_idx;
    logic [WAYS-1:0]         tail_way;
    logic [DEPTH-1:0]        valid;
    logic                    one, empty, full;
    logic                    starved, fire, coalesce, push;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;

    assign wdata = '{idx: io_req_bits_idx,
                     way_en: io_req_bits_way_en,
                     tag: io_req_bits_tag};

    assign starved       = starve_q == STARVE_CNT_W'(STARVE_LIMIT);
    assign io_array_wen  = !reset && !empty && (!io_read_active || starved);
    assign io_read_block = !reset && !empty && io_read_active && starved;
    assign io_req_ready  = !reset && (!full || io_array_wen);
    assign io_busy       = !reset && !empty;

    assign io_array_idx    = io_array_wen ? head.idx    : '0;
    assign io_array_way_en = io_array_wen ? head.way_en : '0;
    assign io_array_tag    = io_array_wen ? head.tag    : '0;

    // A lone entry being written this cycle cannot absorb a new tag.
    assign fire     = io_req_valid && io_req_ready;
    assign coalesce = fire && !empty
                   && tail_idx == io_req_bits_idx
                   && tail_way == io_req_bits_way_en
                   && !(one && io_array_wen);
    assign push     = fire && !coalesce;

    always_comb begin
        starve_d = starve_q;
        if (io_array_wen)
            starve_d = '0;
        else if (!empty && io_read_active && !starved)
            starve_d = starve_q + STARVE_CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end

    always_comb begin
        io_probe_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid[i] && ent[i].idx == io_probe_idx)
                io_probe_pending = 1'b1;
        if (reset)
            io_probe_pending = 1'b0;
    end

    meta_write_fifo #(.N(DEPTH)) u_fifo (
        .clk_i      (clock),
        .rst_i      (reset),
        .push_i     (push),
        .pop_i      (io_array_wen),
        .ovr_i      (coalesce),
        .wdata_i    (wdata),
        .head_o     (head),
        .tail_idx_o (tail_idx),
        .tail_way_o (tail_way),
        .ent_o      (ent),
        .valid_o    (valid),
        .one_o      (one),
        .empty_o    (empty),
        .full_o     (full)
    );

endmodule
